mddc_devfsm_multichannel: RTL and testbench
===========================================

Name: mddc_devfsm_multichannel

Overview:
- Parametrised device behaviour model. Snoops a simple write-address/data bus, shadows a channel-enable register, a time-scale register and a status register, and runs one timed state machine per channel plus a global state machine.
- Replaces the fixed two-state, two-channel device FSM with an N-channel block. Adds arm/drain delays, abort detection and a W1C status register.
- Sits beside the bus model in the device-description-generated testbench and drives feedback to the checker.

Parameters:
- NUM_CH, 4, number of channels (1..16).
- ADDR_W, 32, bus address width.
- DATA_W, 32, bus data width (must be >= NUM_CH and >= TS_W).
- EN_ADDR, 32'd0, channel-enable register address.
- TS_ADDR, 32'd4, time-scale register address.
- STS_ADDR, 32'd8, abort-status register address (W1C).
- TS_W, 16, time-scale counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- access_type  in  1  1 = write, 0 = read (reads ignored).
- address  in  ADDR_W  bus address.
- data  in  DATA_W  bus write data.
- ready  in  1  transfer qualifier; a transfer occurs on a clk edge with ready=1.
- ch_state  out  2*NUM_CH  packed per-channel state, channel i at [2i+1:2i].
- feedback  out  NUM_CH  bit i = 1 when channel i is ON.
- abort  out  NUM_CH  sticky abort flags (STS register contents).
- glob_state  out  2  global state encoding.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs and registers are 0: en_reg, ts_reg, abort, all channels OFF, glob_state G_IDLE.
- Write: a cycle with ready=1 and access_type=1.
  - Only exact address matches count.
  - Other addresses and reads have no effect.
- Register updates:
  - EN_ADDR write: en_reg <= data[NUM_CH-1:0].
  - TS_ADDR write: ts_reg <= data[TS_W-1:0].
  - STS_ADDR write: abort[i] cleared where data[i]=1.
- Channel FSM states (2-bit): OFF=0, ARMING=1, ON=2, DRAIN=3.
- Channel events are evaluated only on an EN_ADDR write. rise_i = new bit 1, old bit 0; fall_i = new bit 0, old bit 1.
- Transitions:
  - OFF + rise: go to ARMING, cnt <= ts_reg.
  - ARMING: cnt decrements each cycle. When cnt==0 at a clock edge (and no fall), go to ON. ts_reg=0 gives ARMING for exactly 1 cycle; ts_reg=N gives N+1 cycles.
  - ARMING + fall: go to OFF and set abort[i] (fall has priority over expiry in the same cycle).
  - ON + fall: go to DRAIN, cnt <= ts_reg.
  - DRAIN: decrement; cnt==0 goes to OFF.
  - DRAIN + rise: go to ON, counter discarded, no abort.
  - Writes that leave bit i unchanged have no effect on channel i.
- Counter load uses the ts_reg value before the current cycle's write. A TS write never affects a running count.
- Abort set vs clear:
  - Same-cycle set and STS clear cannot occur (single address per cycle).
  - A set is sticky until a W1C write.
- Global FSM, registered, updated every cycle from next channel states:
  - G_IDLE=0: no channel ON.
  - G_ACTIVE=1: at least one channel ON, not all.
  - G_FULL=2: all channels ON.
  - Value 3 is unused.
- Latency: ch_state, feedback and glob_state reflect an EN write 1 cycle after the write edge. glob_state updates in the same cycle as feedback.
- Reset mid-count: everything returns to OFF/0 immediately (asynchronous). No pending transition survives reset.
- NUM_CH=1: G_ACTIVE is unreachable; state goes G_IDLE <-> G_FULL.

Decomposition:
- Package mddc_devfsm_pkg: ch_state_e (OFF/ARMING/ON/DRAIN), glob_state_e (G_IDLE/G_ACTIVE/G_FULL), default address constants.
- Sub-module mddc_devfsm_chan: one channel FSM plus TS_W down-counter. Inputs rise, fall, ts_load; outputs state and abort_set. Instantiated NUM_CH times via generate.
- Top level holds the register shadows, edge detection, abort register and global FSM.

Test Plan:
- Arm/on: write TS=3, then EN=0x1 → ch0 ARMING for 4 cycles, then ON; feedback=0x1, glob_state=G_ACTIVE.
- Zero scale, all channels: TS=0, EN=0xF → ARMING 1 cycle, all ON next cycle; glob_state=G_FULL, feedback=0xF.
- Abort: TS=10, EN=0x2, after 2 cycles EN=0x0 → ch1 OFF next cycle; abort=0x2. Then STS write 0x2 → abort=0x0.
- Drain and re-enable: ch0 ON, TS=5, EN=0x0, after 2 cycles EN=0x1 → DRAIN then ON. No abort, counter never reached 0.
- Non-effecting traffic: reads to EN_ADDR, writes with ready=0, and writes to address 0xC → no state or register change.
- Async reset asserted mid-ARMING with TS=100 → all outputs 0 immediately. After release, EN=0x1 arms from ts_reg=0 (1 cycle).

Source files
------------

// File: rtl/mddc_devfsm_multichannel_pkg.sv
// Shared types and default register addresses for the multichannel device FSM.
// Channel and global state encodings match what the checker expects on ch_state/glob_state.
package mddc_devfsm_pkg;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      ARMING = 2'd1,
      ON     = 2'd2,
      DRAIN  = 2'd3
   } ch_state_e;

   typedef enum logic [1:0] {
      G_IDLE   = 2'd0,
      G_ACTIVE = 2'd1,
      G_FULL   = 2'd2
   } glob_state_e;

   localparam logic [31:0] DEF_EN_ADDR  = 32'd0;
   localparam logic [31:0] DEF_TS_ADDR  = 32'd4;
   localparam logic [31:0] DEF_STS_ADDR = 32'd8;

endpackage

// File: rtl/mddc_devfsm_multichannel_if.sv
// Snooped write-address/data bus; the bus model drives it, the device FSM observes it.
// A transfer happens on a clk edge with ready=1; access_type=1 marks a write, reads are ignored.
interface mddc_devfsm_multichannel_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              access_type;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              ready;

   modport master (output access_type, output address, output data, output ready);
   modport slave  (input  access_type, input  address, input  data, input  ready);
endinterface

// File: rtl/mddc_devfsm_multichannel_chan.sv
// One channel: OFF/ARMING/ON/DRAIN state machine with a down-counter for arm and drain delays.
// state_nxt is exported so the global FSM can update in the same cycle as the channel.
module mddc_devfsm_chan
   import mddc_devfsm_pkg::*;
#(
   parameter int TS_W = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rise,
   input  logic            fall,
   input  logic [TS_W-1:0] ts_load,
   output ch_state_e       state,
   output ch_state_e       state_nxt,
   output logic            abort_set
);

   localparam logic [TS_W-1:0] CNT_ONE = TS_W'(1);

   logic [TS_W-1:0] cnt;
   logic [TS_W-1:0] cnt_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      abort_set = 1'b0;
      case (state)
         OFF: begin
            if (rise) begin
               state_nxt = ARMING;
               cnt_nxt   = ts_load;
            end
         end
         ARMING: begin
            // A fall wins over an expiry landing on the same edge.
            if (fall) begin
               state_nxt = OFF;
               cnt_nxt   = '0;
               abort_set = 1'b1;
            end else if (cnt == '0) begin
               state_nxt = ON;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         ON: begin
            if (fall) begin
               state_nxt = DRAIN;
               cnt_nxt   = ts_load;
            end
         end
         DRAIN: begin
            if (rise) begin
               state_nxt = ON;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               state_nxt = OFF;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         default: begin
            state_nxt = OFF;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= OFF;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: rtl/mddc_devfsm_multichannel.sv
// N-channel device behaviour model: shadows EN/TS/STS registers from the snooped bus,
// runs one timed FSM per channel and a global IDLE/ACTIVE/FULL summary FSM.
module mddc_devfsm_multichannel
   import mddc_devfsm_pkg::*;
#(
   parameter int                NUM_CH   = 4,
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] EN_ADDR  = ADDR_W'(DEF_EN_ADDR),
   parameter logic [ADDR_W-1:0] TS_ADDR  = ADDR_W'(DEF_TS_ADDR),
   parameter logic [ADDR_W-1:0] STS_ADDR = ADDR_W'(DEF_STS_ADDR),
   parameter int                TS_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mddc_devfsm_multichannel_if.slave    bus,
   output logic [2*NUM_CH-1:0]          ch_state,
   output logic [NUM_CH-1:0]            feedback,
   output logic [NUM_CH-1:0]            abort,
   output logic [1:0]                   glob_state
);

   logic              wr;
   logic              en_wr;
   logic              ts_wr;
   logic              sts_wr;
   logic [NUM_CH-1:0] en_new;
   logic [NUM_CH-1:0] en_reg;
   logic [TS_W-1:0]   ts_reg;
   logic [NUM_CH-1:0] abort_q;
   logic [NUM_CH-1:0] abort_set_v;
   logic [NUM_CH-1:0] clr_mask;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;
   logic [NUM_CH-1:0] on_nxt;
   glob_state_e       glob_q;
   glob_state_e       glob_nxt;
   ch_state_e         st     [NUM_CH];
   ch_state_e         st_nxt [NUM_CH];
   logic              unused_data;

   assign wr     = bus.ready & bus.access_type;
   assign en_wr  = wr && (bus.address == EN_ADDR);
   assign ts_wr  = wr && (bus.address == TS_ADDR);
   assign sts_wr = wr && (bus.address == STS_ADDR);
   assign en_new = bus.data[NUM_CH-1:0];
   assign unused_data = ^bus.data;

   // Channel events exist only on an EN write and only for bits that actually toggle.
   assign rise     = en_wr  ? (en_new & ~en_reg) : '0;
   assign fall     = en_wr  ? (~en_new & en_reg) : '0;
   assign clr_mask = sts_wr ? bus.data[NUM_CH-1:0] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_reg  <= '0;
         ts_reg  <= '0;
         abort_q <= '0;
      end else begin
         if (en_wr) en_reg <= en_new;
         if (ts_wr) ts_reg <= bus.data[TS_W-1:0];
         abort_q <= (abort_q & ~clr_mask) | abort_set_v;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mddc_devfsm_chan #(.TS_W(TS_W)) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .rise      (rise[i]),
         .fall      (fall[i]),
         .ts_load   (ts_reg),
         .state     (st[i]),
         .state_nxt (st_nxt[i]),
         .abort_set (abort_set_v[i])
      );
      assign ch_state[2*i +: 2] = st[i];
      assign feedback[i]        = (st[i] == ON);
      assign on_nxt[i]          = (st_nxt[i] == ON);
   end

   // Built from next channel states so glob_state moves on the same edge as feedback.
   always_comb begin
      glob_nxt = G_IDLE;
      if (&on_nxt)      glob_nxt = G_FULL;
      else if (|on_nxt) glob_nxt = G_ACTIVE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) glob_q <= G_IDLE;
      else        glob_q <= glob_nxt;
   end

   assign glob_state = glob_q;
   assign abort      = abort_q;

endmodule

// File: tb/tb_mddc_devfsm_multichannel.sv
// Directed table-driven bench for mddc_devfsm_multichannel (NUM_CH=4), plus a bounded arm-delay sequence.
module tb_mddc_devfsm_multichannel;

   localparam int K_BUS = 0;
   localparam int K_RST = 1;

   typedef struct {
      int          kind;
      logic        at;
      logic [31:0] addr;
      logic [31:0] data;
      logic        rdy;
      logic [7:0]  exp_st;
      logic [3:0]  exp_fb;
      logic [3:0]  exp_ab;
      logic [1:0]  exp_gl;
      string       name;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] ch_state;
   logic [3:0] feedback;
   logic [3:0] abort;
   logic [1:0] glob_state;

   int tests = 0;
   int fails = 0;
   vec_t vecs[$];

   mddc_devfsm_multichannel_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mddc_devfsm_multichannel dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .ch_state   (ch_state),
      .feedback   (feedback),
      .abort      (abort),
      .glob_state (glob_state)
   );

   always #5 clk = ~clk;

   function automatic void add(int kind, logic at, logic [31:0] addr, logic [31:0] data, logic rdy,
                               logic [7:0] st, logic [3:0] fb, logic [3:0] ab, logic [1:0] gl, string name);
      vec_t v;
      v.kind = kind; v.at = at; v.addr = addr; v.data = data; v.rdy = rdy;
      v.exp_st = st; v.exp_fb = fb; v.exp_ab = ab; v.exp_gl = gl; v.name = name;
      vecs.push_back(v);
   endfunction

   function automatic void wr(logic [31:0] addr, logic [31:0] data,
                              logic [7:0] st, logic [3:0] fb, logic [3:0] ab, logic [1:0] gl, string name);
      add(K_BUS, 1'b1, addr, data, 1'b1, st, fb, ab, gl, name);
   endfunction

   function automatic void idle(logic [7:0] st, logic [3:0] fb, logic [3:0] ab, logic [1:0] gl, string name);
      add(K_BUS, 1'b0, 32'h0, 32'h0, 1'b0, st, fb, ab, gl, name);
   endfunction

   function automatic void rst(string name);
      add(K_RST, 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 4'h0, 4'h0, 2'd0, name);
   endfunction

   task automatic drive(logic at, logic [31:0] addr, logic [31:0] data, logic rdy);
      bus.access_type = at;
      bus.address     = addr;
      bus.data        = data;
      bus.ready       = rdy;
   endtask

   task automatic bus_cycle(logic at, logic [31:0] addr, logic [31:0] data, logic rdy);
      @(negedge clk);
      drive(at, addr, data, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic check(vec_t v);
      tests++;
      if ({ch_state, feedback, abort, glob_state} !== {v.exp_st, v.exp_fb, v.exp_ab, v.exp_gl}) begin
         fails++;
         $display("FAIL %s: got st=%h fb=%h ab=%h gl=%0d, want st=%h fb=%h ab=%h gl=%0d",
                  v.name, ch_state, feedback, abort, glob_state, v.exp_st, v.exp_fb, v.exp_ab, v.exp_gl);
      end
   endtask

   task automatic check_val(string name, int got, int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   initial begin
      int n;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Arm with TS=3: four ARMING cycles, then ON.
      rst("reset_a");
      wr(32'h4, 32'd3, 8'h00, 4'h0, 4'h0, 2'd0, "a_ts3");
      wr(32'h0, 32'h1, 8'h01, 4'h0, 4'h0, 2'd0, "a_en1_arm1");
      idle(8'h01, 4'h0, 4'h0, 2'd0, "a_arm2");
      idle(8'h01, 4'h0, 4'h0, 2'd0, "a_arm3");
      idle(8'h01, 4'h0, 4'h0, 2'd0, "a_arm4");
      idle(8'h02, 4'h1, 4'h0, 2'd1, "a_on");
      // Zero scale, all channels.
      wr(32'h4, 32'd0, 8'h02, 4'h1, 4'h0, 2'd1, "b_ts0");
      wr(32'h0, 32'hF, 8'h56, 4'h1, 4'h0, 2'd1, "b_enF_arm");
      idle(8'hAA, 4'hF, 4'h0, 2'd2, "b_full");
      wr(32'h0, 32'hE, 8'hAB, 4'hE, 4'h0, 2'd1, "b_ch0_drain0");
      idle(8'hA8, 4'hE, 4'h0, 2'd1, "b_ch0_off");
      // Abort during ARMING, then W1C.
      rst("reset_c");
      wr(32'h4, 32'd10, 8'h00, 4'h0, 4'h0, 2'd0, "c_ts10");
      wr(32'h0, 32'h2, 8'h04, 4'h0, 4'h0, 2'd0, "c_en2");
      idle(8'h04, 4'h0, 4'h0, 2'd0, "c_arm2");
      idle(8'h04, 4'h0, 4'h0, 2'd0, "c_arm3");
      wr(32'h0, 32'h0, 8'h00, 4'h0, 4'h2, 2'd0, "c_abort");
      idle(8'h00, 4'h0, 4'h2, 2'd0, "c_abort_sticky");
      wr(32'h8, 32'h1, 8'h00, 4'h0, 4'h2, 2'd0, "c_w1c_other_bit");
      wr(32'h8, 32'h2, 8'h00, 4'h0, 4'h0, 2'd0, "c_w1c_clear");
      // Drain, re-enable mid-drain, then a full drain of TS+1 cycles.
      rst("reset_d");
      wr(32'h0, 32'h1, 8'h01, 4'h0, 4'h0, 2'd0, "d_arm");
      idle(8'h02, 4'h1, 4'h0, 2'd1, "d_on");
      wr(32'h4, 32'd5, 8'h02, 4'h1, 4'h0, 2'd1, "d_ts5");
      wr(32'h0, 32'h0, 8'h03, 4'h0, 4'h0, 2'd0, "d_drain");
      idle(8'h03, 4'h0, 4'h0, 2'd0, "d_drain2");
      idle(8'h03, 4'h0, 4'h0, 2'd0, "d_drain3");
      wr(32'h0, 32'h1, 8'h02, 4'h1, 4'h0, 2'd1, "d_reenable");
      wr(32'h0, 32'h0, 8'h03, 4'h0, 4'h0, 2'd0, "d_drain_full1");
      for (int i = 0; i < 5; i++) idle(8'h03, 4'h0, 4'h0, 2'd0, "d_drain_full_n");
      idle(8'h00, 4'h0, 4'h0, 2'd0, "d_drain_done");
      // TS write during a running count does not disturb it.
      rst("reset_e");
      wr(32'h4, 32'd2, 8'h00, 4'h0, 4'h0, 2'd0, "e_ts2");
      wr(32'h0, 32'h1, 8'h01, 4'h0, 4'h0, 2'd0, "e_arm1");
      wr(32'h4, 32'd0, 8'h01, 4'h0, 4'h0, 2'd0, "e_ts_write_mid");
      idle(8'h01, 4'h0, 4'h0, 2'd0, "e_arm3");
      idle(8'h02, 4'h1, 4'h0, 2'd1, "e_on");
      // Non-effecting traffic: reads, ready=0, unmapped address, unchanged bits.
      add(K_BUS, 1'b0, 32'h0, 32'h0, 1'b1, 8'h02, 4'h1, 4'h0, 2'd1, "f_read_en");
      add(K_BUS, 1'b1, 32'h0, 32'h0, 1'b0, 8'h02, 4'h1, 4'h0, 2'd1, "f_wr_noready");
      add(K_BUS, 1'b1, 32'hC, 32'h0, 1'b1, 8'h02, 4'h1, 4'h0, 2'd1, "f_wr_addrC");
      add(K_BUS, 1'b1, 32'h4, 32'd9, 1'b0, 8'h02, 4'h1, 4'h0, 2'd1, "f_ts_noready");
      add(K_BUS, 1'b0, 32'h4, 32'd9, 1'b1, 8'h02, 4'h1, 4'h0, 2'd1, "f_ts_read");
      wr(32'h0, 32'h1, 8'h02, 4'h1, 4'h0, 2'd1, "f_en_unchanged");
      wr(32'h0, 32'h0, 8'h03, 4'h0, 4'h0, 2'd0, "f_drain_ts0");
      idle(8'h00, 4'h0, 4'h0, 2'd0, "f_off_ts_kept0");
      // Async reset mid-ARMING with a long scale.
      rst("reset_g");
      wr(32'h4, 32'd100, 8'h00, 4'h0, 4'h0, 2'd0, "g_ts100");
      wr(32'h0, 32'h1, 8'h01, 4'h0, 4'h0, 2'd0, "g_arm");
      idle(8'h01, 4'h0, 4'h0, 2'd0, "g_arm2");
      rst("g_reset_mid_arm");
      wr(32'h0, 32'h1, 8'h01, 4'h0, 4'h0, 2'd0, "g_rearm");
      idle(8'h02, 4'h1, 4'h0, 2'd1, "g_on_ts0");

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].kind == K_RST) begin
            @(negedge clk);
            drive(1'b0, 32'h0, 32'h0, 1'b0);
            #2 rst_n = 1'b0;
            #1 check(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            bus_cycle(vecs[i].at, vecs[i].addr, vecs[i].data, vecs[i].rdy);
            check(vecs[i]);
         end
      end

      // TS=7 on channels 0 and 2: ON must appear exactly 8 edges after the EN write.
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus_cycle(1'b1, 32'h4, 32'd7, 1'b1);
      bus_cycle(1'b1, 32'h0, 32'h5, 1'b1);
      check_val("h_arm_state", int'(ch_state), 8'h11);
      n = 0;
      while (feedback != 4'h5 && n < 20) begin
         bus_cycle(1'b0, 32'h0, 32'h0, 1'b0);
         n++;
      end
      check_val("h_arm_cycles", n, 8);
      check_val("h_on_state", int'(ch_state), 8'h22);
      check_val("h_glob_active", int'(glob_state), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
